// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial SRAM responder: READ (0x03) / WRITE (0x02) with 24-bit address,
// sequential byte streaming from an internal byte array; inputs oversampled on clk.
module spi_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic                 miso,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] last_addr
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

  state_t               state;
  logic [2:0]           sclk_sync;
  logic [1:0]           mosi_sync;
  logic [1:0]           cs_sync;
  logic [7:0]           rx_sh;
  logic [7:0]           tx_sh;
  logic [ADDR_BITS-1:0] addr;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 is_read;
  logic                 primed;
  logic [7:0]           mem [DEPTH];

  logic                 rise_c;
  logic                 fall_c;
  logic                 mosi_c;
  logic                 cs_c;
  logic [7:0]           rx_next_c;
  logic [ADDR_BITS-1:0] addr_next_c;
  logic [ADDR_BITS-1:0] addr_inc_c;
  logic                 wr_en_c;

  // Two-flop synchronisers; sclk keeps a third stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs_n};
    end
  end

  always_comb begin
    rise_c      = sclk_sync[1] & ~sclk_sync[2];
    fall_c      = ~sclk_sync[1] & sclk_sync[2];
    mosi_c      = mosi_sync[1];
    cs_c        = cs_sync[1];
    rx_next_c   = {rx_sh[6:0], mosi_c};
    addr_next_c = {addr[ADDR_BITS-2:0], mosi_c};
    addr_inc_c  = addr + ADDR_BITS'(1);
    wr_en_c     = (state == WDATA) && rise_c && (bit_cnt == CNT_W'(7)) && !cs_c;
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[addr] <= rx_next_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      miso      <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      last_addr <= '0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      addr      <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      primed    <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      busy      <= ~cs_c;
      if (cs_c) begin
        state   <= IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
        primed  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
            rx_sh   <= 8'h00;
            miso    <= 1'b0;
          end
          CMD: if (rise_c) begin
            rx_sh <= rx_next_c;
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              if (rx_next_c == CMD_READ) begin
                is_read <= 1'b1;
                state   <= ADDR;
              end else if (rx_next_c == CMD_WRITE) begin
                is_read <= 1'b0;
                state   <= ADDR;
              end else begin
                state <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ADDR: if (rise_c) begin
            addr <= addr_next_c;
            if (bit_cnt == CNT_W'(23)) begin
              bit_cnt <= '0;
              if (is_read) begin
                tx_sh     <= mem[addr_next_c];
                miso      <= mem[addr_next_c][7];
                last_addr <= addr_next_c;
                primed    <= 1'b0;
                state     <= RDATA;
              end else begin
                state <= WDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          // The fall right after the last address rise must keep the first MSB
          RDATA: if (fall_c) begin
            if (!primed) begin
              primed <= 1'b1;
            end else if (bit_cnt == CNT_W'(7)) begin
              bit_cnt   <= '0;
              addr      <= addr_inc_c;
              tx_sh     <= mem[addr_inc_c];
              miso      <= mem[addr_inc_c][7];
              last_addr <= addr_inc_c;
            end else begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              miso    <= tx_sh[6];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WDATA: if (rise_c) begin
            rx_sh <= rx_next_c;
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt   <= '0;
              wr_strobe <= 1'b1;
              last_addr <= addr;
              addr      <= addr_inc_c;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          IGNORE:  miso  <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: writes, reads, wrap, aliasing, aborts and reset.
module tb_spi_mem_responder;

  localparam int unsigned HP = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] last_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  spi_mem_responder #(.DEPTH(256), .ADDR_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .busy(busy), .wr_strobe(wr_strobe), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe === 1'b1) strobes <= strobes + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: drive mosi, sample miso just before the rise, then fall
  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(HP);
    r = miso;
    sclk = 1'b1;
    wait_clk(HP);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] o, output logic [7:0] i);
    logic r;
    for (int k = 7; k >= 0; k--) begin
      spi_bit(o[k], r);
      i[k] = r;
    end
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] dummy;
    cs_n = 1'b0;
    wait_clk(4);
    xfer(cmd, dummy);
    xfer(a[23:16], dummy);
    xfer(a[15:8], dummy);
    xfer(a[7:0], dummy);
  endtask

  task automatic end_tx();
    wait_clk(HP);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] d [$]);
    logic [7:0] dummy;
    start_cmd(8'h02, a);
    foreach (d[k]) xfer(d[k], dummy);
    end_tx();
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input logic [7:0] d [$]);
    logic [7:0] got;
    start_cmd(8'h03, a);
    foreach (d[k]) begin
      xfer(8'h00, got);
      check($sformatf("%s[%0d]", tag, k), 32'(got), 32'(d[k]));
    end
    end_tx();
  endtask

  initial begin
    int s0;
    logic r;
    logic any_one;
    logic [7:0] dummy;

    wait_clk(5);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_last_addr", 32'(last_addr), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // Four-byte write then read back
    s0 = strobes;
    start_cmd(8'h02, 24'h000010);
    check("busy_active", 32'(busy), 32'h1);
    xfer(8'h13, dummy);
    xfer(8'h05, dummy);
    xfer(8'h00, dummy);
    xfer(8'h00, dummy);
    end_tx();
    check("busy_idle", 32'(busy), 32'h0);
    check("wr4_strobes", 32'(strobes - s0), 32'd4);
    check("wr4_last_addr", 32'(last_addr), 32'h13);
    read_check("rd4", 24'h000010, '{8'h13, 8'h05, 8'h00, 8'h00});
    check("rd4_last_addr", 32'(last_addr), 32'h14);

    // Wrap at DEPTH-1
    s0 = strobes;
    write_bytes(24'h0000FF, '{8'hAA, 8'hBB});
    check("wrap_strobes", 32'(strobes - s0), 32'd2);
    check("wrap_last_addr", 32'(last_addr), 32'h00);
    read_check("wrap_rd", 24'h0000FF, '{8'hAA, 8'hBB});
    check("wrap_rd_last_addr", 32'(last_addr), 32'h01);

    // Reset in the middle of a read: 0xAA bit5 is 1 after two data bits
    start_cmd(8'h03, 24'h0000FF);
    spi_bit(1'b0, r);
    spi_bit(1'b0, r);
    wait_clk(4);
    check("pre_rst_miso", 32'(miso), 32'h1);
    sclk = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(miso), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_last_addr", 32'(last_addr), 32'h0);
    wait_clk(2);
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    read_check("post_rst_rd", 24'h0000FF, '{8'hAA, 8'hBB});

    // Upper address bits alias
    write_bytes(24'h012345, '{8'h5A});
    check("alias_last_addr", 32'(last_addr), 32'h45);
    read_check("alias_rd", 24'h000045, '{8'h5A});

    // Abandoned partial byte must not commit
    write_bytes(24'h000020, '{8'h11, 8'h22});
    s0 = strobes;
    start_cmd(8'h02, 24'h000020);
    xfer(8'h77, dummy);
    for (int k = 0; k < 5; k++) spi_bit(1'b1, r);
    end_tx();
    check("partial_strobes", 32'(strobes - s0), 32'd1);
    check("partial_last_addr", 32'(last_addr), 32'h20);
    read_check("partial_rd", 24'h000020, '{8'h77, 8'h22});

    // Unknown command is ignored
    s0 = strobes;
    cs_n = 1'b0;
    wait_clk(4);
    xfer(8'h9F, dummy);
    any_one = 1'b0;
    for (int k = 0; k < 32; k++) begin
      spi_bit(k[0], r);
      if (r !== 1'b0) any_one = 1'b1;
    end
    end_tx();
    check("ign_miso", 32'(any_one), 32'h0);
    check("ign_strobes", 32'(strobes - s0), 32'd0);
    read_check("after_ign_rd", 24'h000010, '{8'h13});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
